// File: rtl/alu_if.sv
// ALU operand/opcode/result bundle.
// The master drives operands and opcode; the slave (the ALU) returns the
// registered result and condition codes.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       n;
    logic [3:0]       cc;
    logic [WIDTH-1:0] tr;

    modport master (
        output a,
        output b,
        output n,
        input  cc,
        input  tr
    );

    modport slave (
        input  a,
        input  b,
        input  n,
        output cc,
        output tr
    );
endinterface

// File: rtl/alu.sv
// Single-cycle registered ALU.
// The result tr and flags cc = {N,Z,C,V} update one rising edge after the
// operands and opcode are presented. NOP and LOAD hold both registers.
// CMP updates only the flags.
// Arithmetic ops share one adder:
//   ADD: a + b + 0
//   SUB: a + ~b + 1
//   CMP: a + ~b + 1
//   INC: a + 0 + 1
//   DEC: a + all-ones + 0
// The adder carry-out is the carry for additions and the "no borrow" flag
// for subtractions.
module alu #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_INC   = 4'd10;
    localparam logic [3:0] OP_DEC   = 4'd11;
    localparam logic [3:0] OP_CMP   = 4'd12;
    localparam logic [3:0] OP_PASSA = 4'd13;
    localparam logic [3:0] OP_ROL   = 4'd14;
    localparam logic [3:0] OP_ROR   = 4'd15;

    // Sum of x + y + cin, with the carry-out in the top bit.
    function automatic logic [WIDTH:0] add_carry(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        add_carry = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Two's complement overflow of x + y (+cin).
    // Overflow occurs when both addends share a sign and the result does not.
    function automatic logic add_ovf(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] r
    );
        add_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    endfunction

    // Assemble {N,Z,C,V}; N and Z always come from the value itself.
    function automatic logic [3:0] pack_cc(
        input logic [WIDTH-1:0] r,
        input logic             c,
        input logic             v
    );
        pack_cc = {r[WIDTH-1], ~|r, c, v};
    endfunction

    logic [WIDTH-1:0] tr_d;
    logic [WIDTH-1:0] tr_q;
    logic [3:0]       cc_d;
    logic [3:0]       cc_q;

    logic [WIDTH-1:0] addend_s;
    logic             carry_in_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] sum_res_s;
    logic             sum_ovf_s;
    logic [WIDTH-1:0] logic_res_s;

    // Select the second adder operand and carry-in for the arithmetic opcodes.
    always_comb begin
        addend_s   = '0;
        carry_in_s = 1'b0;
        case (bus.n)
            OP_ADD: begin
                addend_s   = bus.b;
                carry_in_s = 1'b0;
            end
            OP_SUB, OP_CMP: begin
                addend_s   = ~bus.b;
                carry_in_s = 1'b1;
            end
            OP_INC: begin
                addend_s   = '0;
                carry_in_s = 1'b1;
            end
            OP_DEC: begin
                addend_s   = '1;
                carry_in_s = 1'b0;
            end
            default: begin
                addend_s   = '0;
                carry_in_s = 1'b0;
            end
        endcase
    end

    assign sum_s     = add_carry(bus.a, addend_s, carry_in_s);
    assign sum_res_s = sum_s[WIDTH-1:0];
    assign sum_ovf_s = add_ovf(bus.a, addend_s, sum_res_s);

    // Compute the next result and flags for the presented opcode.
    always_comb begin
        tr_d        = tr_q;
        cc_d        = cc_q;
        logic_res_s = '0;
        case (bus.n)
            OP_NOP, OP_LOAD: begin
                tr_d = tr_q;
                cc_d = cc_q;
            end
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                tr_d = sum_res_s;
                cc_d = pack_cc(sum_res_s, sum_s[WIDTH], sum_ovf_s);
            end
            OP_CMP: begin
                tr_d = tr_q;
                cc_d = pack_cc(sum_res_s, sum_s[WIDTH], sum_ovf_s);
            end
            OP_AND: begin
                logic_res_s = bus.a & bus.b;
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, 1'b0, 1'b0);
            end
            OP_OR: begin
                logic_res_s = bus.a | bus.b;
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, 1'b0, 1'b0);
            end
            OP_XOR: begin
                logic_res_s = bus.a ^ bus.b;
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, 1'b0, 1'b0);
            end
            OP_NOT: begin
                logic_res_s = ~bus.a;
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, 1'b0, 1'b0);
            end
            OP_PASSA: begin
                logic_res_s = bus.a;
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, 1'b0, 1'b0);
            end
            OP_SHL: begin
                logic_res_s = {bus.a[WIDTH-2:0], 1'b0};
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, bus.a[WIDTH-1], 1'b0);
            end
            OP_SHR: begin
                logic_res_s = {1'b0, bus.a[WIDTH-1:1]};
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, bus.a[0], 1'b0);
            end
            OP_ROL: begin
                logic_res_s = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, bus.a[WIDTH-1], 1'b0);
            end
            OP_ROR: begin
                logic_res_s = {bus.a[0], bus.a[WIDTH-1:1]};
                tr_d        = logic_res_s;
                cc_d        = pack_cc(logic_res_s, bus.a[0], 1'b0);
            end
            default: begin
                tr_d = tr_q;
                cc_d = cc_q;
            end
        endcase
    end

    // Result and flag registers; reset discards the operation of that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tr_q <= '0;
            cc_q <= 4'b0000;
        end else begin
            tr_q <= tr_d;
            cc_q <= cc_d;
        end
    end

    assign bus.tr = tr_q;
    assign bus.cc = cc_q;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed vectors plus randomized operations checked
// against an integer-arithmetic reference model.
module tb_alu;

    logic clk;
    logic rst;
    int   checks;
    int   passed;

    logic [7:0] m_tr;
    logic [3:0] m_cc;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned/signed views.
    task automatic model_apply(input logic r, input logic [3:0] op,
                               input logic [7:0] xa, input logic [7:0] xb);
        int ua;
        int ub;
        int sa;
        int sb;
        int full;
        int sfull;
        logic [7:0] res;
        logic c;
        logic v;
        bit upd;

        ua = xa;
        ub = xb;
        sa = $signed(xa);
        sb = $signed(xb);
        full = 0;
        sfull = 0;
        c = 1'b0;
        v = 1'b0;
        upd = 1'b1;

        if (r) begin
            m_tr = 8'h00;
            m_cc = 4'b0000;
            return;
        end

        case (op)
            4'd1:  begin full = ua + ub; sfull = sa + sb; c = (full > 255); end
            4'd2:  begin full = ua - ub; sfull = sa - sb; c = (ua >= ub);  end
            4'd12: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub);  end
            4'd10: begin full = ua + 1;  sfull = sa + 1;  c = (full > 255); end
            4'd11: begin full = ua - 1;  sfull = sa - 1;  c = (ua >= 1);   end
            4'd3:  full = int'(xa & xb);
            4'd4:  full = int'(xa | xb);
            4'd5:  full = int'(xa ^ xb);
            4'd6:  full = 255 - ua;
            4'd7:  begin full = (ua * 2) % 256;             c = (ua >= 128); end
            4'd9:  begin full = ua / 2;                     c = (ua % 2 == 1); end
            4'd13: full = ua;
            4'd14: begin full = (ua * 2) % 256 + ua / 128;  c = (ua >= 128); end
            4'd15: begin full = ua / 2 + (ua % 2) * 128;    c = (ua % 2 == 1); end
            default: upd = 1'b0;
        endcase

        if (op inside {4'd1, 4'd2, 4'd10, 4'd11, 4'd12})
            v = (sfull > 127) || (sfull < -128);

        res = full[7:0];

        if (upd) begin
            m_cc = {res[7], (res == 8'h00), c, v};
            if (op != 4'd12)
                m_tr = res;
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] etr,
                             input logic [3:0] ecc);
        checks++;
        assert (bus.tr === etr) passed++;
        else $error("FAIL %s tr observed %h expected %h", tag, bus.tr, etr);

        checks++;
        assert (bus.cc === ecc) passed++;
        else $error("FAIL %s cc observed %b expected %b", tag, bus.cc, ecc);
    endtask

    // Apply one operation across a rising edge, then compare with the model.
    task automatic step(input string tag, input logic r, input logic [3:0] op,
                        input logic [7:0] xa, input logic [7:0] xb);
        @(negedge clk);
        rst   = r;
        bus.n = op;
        bus.a = xa;
        bus.b = xb;
        @(posedge clk);
        model_apply(r, op, xa, xb);
        #1;
        check_out(tag, m_tr, m_cc);
    endtask

    // Scramble inputs between edges; outputs must not move.
    task automatic scramble_hold(input string tag);
        bus.n = 4'($urandom_range(0, 15));
        bus.a = 8'($urandom_range(0, 255));
        bus.b = 8'($urandom_range(0, 255));
        rst   = 1'($urandom_range(0, 1));
        #2;
        check_out(tag, m_tr, m_cc);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        m_tr   = 8'h00;
        m_cc   = 4'b0000;
        rst    = 1'b1;
        bus.n  = 4'd0;
        bus.a  = 8'h00;
        bus.b  = 8'h00;

        // Reset priority, then first operation.
        step("rst_add", 1'b1, 4'd1, 8'h05, 8'h03);
        check_out("rst_const", 8'h00, 4'b0000);
        step("add_5_3", 1'b0, 4'd1, 8'h05, 8'h03);
        check_out("add_5_3_const", 8'h08, 4'b0000);

        // Subtraction with borrow and with signed overflow.
        step("sub_3_5", 1'b0, 4'd2, 8'h03, 8'h05);
        check_out("sub_3_5_const", 8'hFE, 4'b1000);
        step("sub_80_1", 1'b0, 4'd2, 8'h80, 8'h01);
        check_out("sub_80_1_const", 8'h7F, 4'b0011);

        // Boundary cases.
        step("add_ff_1", 1'b0, 4'd1, 8'hFF, 8'h01);
        check_out("add_ff_1_const", 8'h00, 4'b0110);
        step("inc_7f", 1'b0, 4'd10, 8'h7F, 8'h00);
        check_out("inc_7f_const", 8'h80, 4'b1001);
        step("dec_00", 1'b0, 4'd11, 8'h00, 8'h00);
        check_out("dec_00_const", 8'hFF, 4'b1000);

        // Overflowing add, then NOP holds with new operands.
        step("add_7f_1", 1'b0, 4'd1, 8'h7F, 8'h01);
        check_out("add_7f_1_const", 8'h80, 4'b1001);
        scramble_hold("midcycle_hold");
        step("nop_hold", 1'b0, 4'd0, 8'h12, 8'h34);
        check_out("nop_hold_const", 8'h80, 4'b1001);

        // CMP leaves tr alone; LOAD holds everything.
        step("passa_55", 1'b0, 4'd13, 8'h55, 8'h00);
        step("cmp_eq", 1'b0, 4'd12, 8'h0C, 8'h0C);
        check_out("cmp_eq_const", 8'h55, 4'b0110);
        step("load_hold", 1'b0, 4'd8, 8'hAA, 8'hBB);
        check_out("load_hold_const", 8'h55, 4'b0110);

        // Shifts and rotates.
        step("shl_81", 1'b0, 4'd7, 8'h81, 8'h00);
        check_out("shl_81_const", 8'h02, 4'b0010);
        step("rol_81", 1'b0, 4'd14, 8'h81, 8'h00);
        check_out("rol_81_const", 8'h03, 4'b0010);
        step("ror_01", 1'b0, 4'd15, 8'h01, 8'h00);
        check_out("ror_01_const", 8'h80, 4'b1010);
        step("shr_01", 1'b0, 4'd9, 8'h01, 8'h00);
        check_out("shr_01_const", 8'h00, 4'b0110);

        // Logic ops.
        step("and_zero", 1'b0, 4'd3, 8'hF0, 8'h0F);
        check_out("and_zero_const", 8'h00, 4'b0100);
        step("not_00", 1'b0, 4'd6, 8'h00, 8'h00);
        check_out("not_00_const", 8'hFF, 4'b1000);

        // Reset mid-stream discards the pending operation.
        step("rst_mid", 1'b1, 4'd1, 8'hFF, 8'hFF);
        check_out("rst_mid_const", 8'h00, 4'b0000);

        // Randomized operations against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand_op", ($urandom_range(0, 19) == 0),
                 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
            if (i % 8 == 0)
                scramble_hold("rand_hold");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  WIDTH  operand A.
REQ-005 Port: b  input  WIDTH  operand B.
REQ-006 Port: n  input  4  opcode.
REQ-007 Port: cc  output  4  registered condition codes {N,Z,C,V} = cc[3:0].
REQ-008 Port: tr  output  WIDTH  registered result.

Function
REQ-009 tr and cc SHALL be registers updated only on rising clk; latency exactly 1 cycle from a/b/n to tr/cc.
REQ-010 Opcode map (r = new tr value), SHALL be implemented exactly:
- 0 NOP: tr, cc hold.
- 1 ADD: r = a+b.
- 2 SUB: r = a-b.
- 3 AND: r = a&b.
- 4 OR: r = a|b.
- 5 XOR: r = a^b.
- 6 NOT: r = ~a.
- 7 SHL: r = a<<1, LSB 0.
- 8 LOAD: tr, cc hold (external memory write slot).
- 9 SHR: r = a>>1 logical, MSB 0.
- 10 INC: r = a+1.
- 11 DEC: r = a-1.
- 12 CMP: tr holds; cc from a-b.
- 13 PASSA: r = a.
- 14 ROL: r = {a[W-2:0],a[W-1]}.
- 15 ROR: r = {a[0],a[W-1:1]}.
REQ-011 Arithmetic SHALL be modulo 2^WIDTH; no saturation.
REQ-012 N SHALL equal MSB of the result (CMP: of a-b).
REQ-013 Z SHALL be 1 iff the result (CMP: a-b) is all zeros.
REQ-014 C: ADD/INC = carry-out of bit WIDTH-1; SUB/CMP/DEC = 1 iff no borrow (unsigned a>=b, resp. a>=1); SHL/ROL = old a[W-1]; SHR/ROR = old a[0]; all logic ops and PASSA = 0.
REQ-015 V: ADD/INC = signed overflow (operands same sign, result sign differs); SUB/CMP/DEC = signed overflow (operand signs differ, result sign differs from a); all other updating ops = 0.
REQ-016 On NOP and LOAD, cc and tr SHALL retain previous values bit-for-bit.
REQ-017 Boundary: ADD 0xFF+0x01 -> tr 0x00, Z=1, C=1, V=0; INC 0x7F -> 0x80, N=1, V=1; DEC 0x00 -> 0xFF, C=0.
REQ-018 Operand changes between edges SHALL have no effect on outputs until the next rising edge.
REQ-019 Outputs SHALL never be X/Z after first reset for any known inputs.

Reset
REQ-020 When rst=1 at a rising edge, tr SHALL become 0 and cc SHALL become 4'b0000, regardless of n, a, b.
REQ-021 Reset SHALL take priority over every opcode; first operation executes on the first edge with rst=0.
REQ-022 Reset asserted mid-stream SHALL discard the pending operation of that cycle.

Verification
REQ-023 rst=1 one edge with n=1,a=5,b=3 -> tr=0x00, cc=0000; release, next edge n=1 -> tr=0x08, cc=0000.
REQ-024 n=2, a=0x03, b=0x05 -> tr=0xFE, cc=1000 (N=1, borrow so C=0); a=0x80,b=0x01 -> tr=0x7F, cc=0011.
REQ-025 n=1, a=0x7F, b=0x01 -> tr=0x80, cc=1001; then n=0 with new operands -> tr=0x80, cc=1001 unchanged.
REQ-026 n=12, a=0x0C, b=0x0C after tr=0x55 -> tr stays 0x55, cc=0110; n=8 next -> tr, cc unchanged.
REQ-027 n=7, a=0x81 -> tr=0x02, cc=0010; n=14, a=0x81 -> tr=0x03, cc=0010; n=15, a=0x01 -> tr=0x80, cc=1010.
REQ-028 n=3, a=0xF0, b=0x0F -> tr=0x00, cc=0100; n=6, a=0x00 -> tr=0xFF, cc=1000.
